// File: rtl/cache_ctrl.sv
// cache_ctrl: single-request cache controller.
//   Read hits are served from the cache.
//   Read misses fetch the word from memory and fill the cache.
//   Writes are write-through without write-allocate: the cache is updated
//   only on a hit, and memory is always written.
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   cpu_*            CPU request (re/we/addr/wdata) and response (rdata/ready)
//   hit, cache_*     tag-compare result, cache read data, cache write port
//   mem_*            memory request/ack handshake and data
//   busy             high whenever a request is in flight
//   hit_count,
//   miss_count       saturating 16-bit lookup statistics
module cache_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    input  logic                  hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_MEM_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        fill_d     = fill_q;
        rdata_d    = rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_re || cpu_we) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    // A simultaneous read and write request is taken as a write.
                    we_d    = cpu_we;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                    if (!we_q) rdata_d = cache_rdata;
                    state_d = we_q ? S_MEM_WR : S_RESP;
                end else begin
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                    state_d = we_q ? S_MEM_WR : S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    fill_d  = mem_rdata;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                rdata_d = fill_q;
                state_d = S_RESP;
            end
            S_MEM_WR: begin
                if (mem_ack) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            fill_q     <= '0;
            rdata_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            fill_q     <= fill_d;
            rdata_q    <= rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Control outputs decode directly from the state register, so an
    // asynchronous reset (state forced to IDLE) drops them immediately.
    assign busy        = (state_q != S_IDLE);
    assign cpu_ready   = (state_q == S_RESP);
    assign mem_req     = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign mem_we      = (state_q == S_MEM_WR);
    assign cache_we    = ((state_q == S_LOOKUP) && we_q && hit) || (state_q == S_FILL);
    assign cache_wdata = (state_q == S_FILL) ? fill_q : wdata_q;
    assign cache_addr  = addr_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cpu_rdata   = rdata_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_re = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0, cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        hit = 1'b0;
    logic [7:0]  cache_rdata = '0;
    logic        cache_we;
    logic [7:0]  cache_addr, cache_wdata;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        busy;
    logic [15:0] hit_count, miss_count;

    int tests  = 0;
    int errors = 0;
    int cw_cycles   = 0;
    int rdy_cycles  = 0;
    int mreq_cycles = 0;
    int cw_snap, rdy_snap;

    cache_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .hit(hit), .cache_rdata(cache_rdata),
        .cache_we(cache_we), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cache_we)  cw_cycles++;
        if (cpu_ready) rdy_cycles++;
        if (mem_req)   mreq_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read hit from IDLE; checks response and the expected hit counter.
    task automatic read_hit(input logic [7:0] a, input logic [7:0] d, input logic [15:0] exp_hits);
        cpu_re = 1'b1; cpu_addr = a; hit = 1'b1; cache_rdata = d;
        tick();
        cpu_re = 1'b0;
        tick();
        check("sat_ready", cpu_ready, 1);
        check("sat_rdata", cpu_rdata, d);
        check("sat_hits", hit_count, exp_hits);
        tick();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_ready", cpu_ready, 0);
        check("rst_mreq", mem_req, 0);
        check("rst_cwe", cache_we, 0);
        check("rst_hits", hit_count, 0);
        check("rst_miss", miss_count, 0);
        check("rst_rdata", cpu_rdata, 0);
        tick();
        rst = 1'b1;
        tick();

        // Read hit at 0x10
        cpu_re = 1'b1; cpu_addr = 8'h10; hit = 1'b1; cache_rdata = 8'hA5;
        tick();
        cpu_re = 1'b0;
        check("rh_busy", busy, 1);
        check("rh_caddr", cache_addr, 8'h10);
        check("rh_ready_early", cpu_ready, 0);
        check("rh_cwe", cache_we, 0);
        tick();
        check("rh_ready", cpu_ready, 1);
        check("rh_rdata", cpu_rdata, 8'hA5);
        check("rh_hits", hit_count, 1);
        tick();
        check("rh_ready_1cyc", cpu_ready, 0);
        check("rh_idle", busy, 0);
        check("rh_no_mreq", mreq_cycles, 0);

        // Read miss at 0x20; a stray ack before mem_req must be ignored
        cw_snap = cw_cycles;
        cpu_re = 1'b1; cpu_addr = 8'h20; hit = 1'b0;
        tick();
        cpu_re = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        check("rm_mreq", mem_req, 1);
        check("rm_mwe", mem_we, 0);
        check("rm_maddr", mem_addr, 8'h20);
        check("rm_miss", miss_count, 1);
        tick();
        check("rm_stray_ack_ignored", mem_req, 1);
        tick();
        check("rm_hold", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        check("rm_mreq_drop", mem_req, 0);
        check("rm_fill_we", cache_we, 1);
        check("rm_fill_data", cache_wdata, 8'h3C);
        check("rm_fill_addr", cache_addr, 8'h20);
        tick();
        check("rm_ready", cpu_ready, 1);
        check("rm_rdata", cpu_rdata, 8'h3C);
        check("rm_cwe_off", cache_we, 0);
        tick();
        check("rm_cwe_count", cw_cycles - cw_snap, 1);

        // Write hit 0x11 -> 0x05
        cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 8'h11; hit = 1'b1;
        tick();
        cpu_we = 1'b0;
        check("wh_cwe", cache_we, 1);
        check("wh_cdata", cache_wdata, 8'h11);
        check("wh_caddr", cache_addr, 8'h05);
        tick();
        check("wh_cwe_1cyc", cache_we, 0);
        check("wh_mreq", mem_req, 1);
        check("wh_mwe", mem_we, 1);
        check("wh_mdata", mem_wdata, 8'h11);
        check("wh_maddr", mem_addr, 8'h05);
        check("wh_hits", hit_count, 2);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wh_ready", cpu_ready, 1);
        check("wh_mreq_drop", mem_req, 0);
        check("wh_rdata_hold", cpu_rdata, 8'h3C);
        tick();

        // Write miss 0x22 -> 0x06
        cw_snap = cw_cycles;
        cpu_we = 1'b1; cpu_addr = 8'h06; cpu_wdata = 8'h22; hit = 1'b0;
        tick();
        cpu_we = 1'b0;
        check("wm_cwe", cache_we, 0);
        tick();
        check("wm_mwe", mem_we, 1);
        check("wm_mdata", mem_wdata, 8'h22);
        check("wm_maddr", mem_addr, 8'h06);
        check("wm_miss", miss_count, 2);
        check("wm_hits", hit_count, 2);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wm_ready", cpu_ready, 1);
        tick();
        check("wm_no_cwe", cw_cycles - cw_snap, 0);

        // Simultaneous re/we treated as write; request during RESP ignored
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h07; cpu_wdata = 8'h33; hit = 1'b1;
        tick();
        cpu_re = 1'b0; cpu_we = 1'b0;
        check("rw_cwe", cache_we, 1);
        tick();
        check("rw_mwe", mem_we, 1);
        check("rw_mdata", mem_wdata, 8'h33);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rw_ready", cpu_ready, 1);
        cpu_re = 1'b1; cpu_addr = 8'h40;
        tick();
        cpu_re = 1'b0;
        check("resp_req_ignored", busy, 0);
        check("rw_hits", hit_count, 3);
        check("rw_rdata_hold", cpu_rdata, 8'h3C);
        tick();

        // Reset during MEM_RD
        cpu_re = 1'b1; cpu_addr = 8'h30; hit = 1'b0;
        tick();
        cpu_re = 1'b0;
        tick();
        check("rr_mreq_pre", mem_req, 1);
        cw_snap = cw_cycles; rdy_snap = rdy_cycles;
        #2 rst = 1'b0;
        #1;
        check("rr_mreq_async", mem_req, 0);
        check("rr_busy", busy, 0);
        check("rr_hits", hit_count, 0);
        check("rr_miss", miss_count, 0);
        check("rr_rdata", cpu_rdata, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("rr_idle_after", busy, 0);
        check("rr_no_cwe", cw_cycles - cw_snap, 0);
        check("rr_no_ready", rdy_cycles - rdy_snap, 0);

        // Hit counter saturation: preload near the top, then keep hitting
        force dut.hit_cnt_q = 16'hFFFD;
        tick();
        release dut.hit_cnt_q;
        tick();
        check("sat_preload", hit_count, 16'hFFFD);
        read_hit(8'h01, 8'h5A, 16'hFFFE);
        read_hit(8'h02, 8'h6B, 16'hFFFF);
        read_hit(8'h03, 8'h7C, 16'hFFFF);
        read_hit(8'h04, 8'h8D, 16'hFFFF);
        check("sat_miss_untouched", miss_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the cache and memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the data word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cpu_re / cpu_we, input, 1 each, CPU read / write request, sampled only in IDLE.
REQ-006 SHALL have ports cpu_addr, input, ADDR_WIDTH, and cpu_wdata, input, DATA_WIDTH, the request address and write data.
REQ-007 SHALL have ports cpu_rdata, output, DATA_WIDTH, and cpu_ready, output, 1, read data and the one-cycle completion strobe.
REQ-008 SHALL have ports hit, input, 1, and cache_rdata, input, DATA_WIDTH, the tag-compare result and cache read data for cache_addr.
REQ-009 SHALL have ports cache_we, output, 1; cache_addr, output, ADDR_WIDTH; and cache_wdata, output, DATA_WIDTH, the cache write port.
REQ-010 SHALL have ports mem_req, output, 1; mem_we, output, 1; mem_addr, output, ADDR_WIDTH; and mem_wdata, output, DATA_WIDTH, the memory request.
REQ-011 SHALL have ports mem_ack, input, 1, and mem_rdata, input, DATA_WIDTH, the memory completion and read data.
REQ-012 SHALL have ports busy, output, 1; hit_count, output, 16; and miss_count, output, 16.

Function
REQ-013 SHALL implement the states IDLE, LOOKUP, MEM_RD, FILL, MEM_WR and RESP.
REQ-014 In IDLE, when cpu_re or cpu_we is high, SHALL latch addr, wdata and op, then go to LOOKUP; if both are high, SHALL treat the request as a write.
REQ-015 cache_addr and mem_addr SHALL always equal the latched address.
REQ-016 busy SHALL be high in every state except IDLE.
REQ-017 In LOOKUP (exactly 1 cycle), SHALL sample hit.
REQ-018 On a read hit in LOOKUP, SHALL register cpu_rdata from cache_rdata, increment hit_count and go to RESP.
REQ-019 On a read miss in LOOKUP, SHALL increment miss_count and go to MEM_RD.
REQ-020 On a write hit in LOOKUP, SHALL assert cache_we for that single cycle with cache_wdata set to the latched wdata, then go to MEM_WR.
REQ-021 On a write miss in LOOKUP, SHALL keep cache_we low (no write-allocate), then go to MEM_WR.
REQ-022 A write SHALL increment hit_count or miss_count per hit.
REQ-023 In MEM_RD, SHALL hold mem_req=1 and mem_we=0 until mem_ack is sampled high, then capture mem_rdata and go to FILL.
REQ-024 In MEM_WR, SHALL hold mem_req=1, mem_we=1 and mem_wdata set to the latched wdata until mem_ack is sampled high, then go to RESP.
REQ-025 mem_req SHALL drop in the cycle after the ack edge.
REQ-026 mem_ack while mem_req is low SHALL be ignored.
REQ-027 In FILL (exactly 1 cycle), SHALL assert cache_we with cache_wdata set to the captured fill data, register cpu_rdata to the same value and go to RESP.
REQ-028 In RESP, SHALL assert cpu_ready for exactly 1 cycle, then return to IDLE; requests present during RESP SHALL be ignored.
REQ-029 cpu_rdata SHALL hold its value until the next read completes.
REQ-030 Latency, counting from the request-sampling edge E: read hit SHALL give cpu_ready after E+2; read miss with ack at edge A SHALL give cpu_ready after A+2; write with ack at edge A SHALL give cpu_ready after A+1.
REQ-031 cache_we SHALL be high only in LOOKUP on a write hit and in FILL, and never for more than 1 consecutive cycle.
REQ-032 Counters SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-033 While rst is low, SHALL immediately (asynchronously) force state IDLE.
REQ-034 While rst is low, SHALL force cpu_ready, cache_we, mem_req, mem_we and busy to 0.
REQ-035 While rst is low, SHALL clear cpu_rdata, the latched address and data, hit_count and miss_count to 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction, with no cache write and no cpu_ready.
REQ-037 Deassertion of rst SHALL take effect at the next rising edge with state IDLE.

Verification
REQ-038 Read hit: cpu_re at addr 0x10, hit=1, cache_rdata=0xA5 -> cpu_rdata=0xA5, cpu_ready pulse 2 cycles after sample, mem_req never high, hit_count=1.
REQ-039 Read miss: cpu_re at addr 0x20, hit=0, mem_ack 3 cycles after mem_req with mem_rdata=0x3C -> one cache_we pulse with cache_wdata=0x3C at addr 0x20, cpu_rdata=0x3C, miss_count=1.
REQ-040 Write hit then write miss: 0x11 to 0x05 with hit=1 and 0x22 to 0x06 with hit=0 -> cache_we only for the first write, two mem_we=1 transactions with the correct data, hit_count=1, miss_count=1.
REQ-041 Simultaneous cpu_re=cpu_we=1 -> treated as a write (mem_we=1); a request asserted during RESP -> ignored.
REQ-042 Reset asserted in MEM_RD while mem_req=1 -> mem_req=0 immediately, no cache_we, no cpu_ready, counters=0.
REQ-043 Counter saturation: force 65536 hits -> hit_count stays 16'hFFFF.
